fibo_sequencer: RTL

- Drives the Fibonacci calculator over a range of indices first_n..last_n.
- Issues one begin_fibo pulse per index and captures the 16-bit result when the calculator's done asserts.
- Buffers results in a small FIFO and presents them on a valid/ready output stream.
- Sits directly upstream of the calculator (request side) and downstream of it (result side), and absorbs consumer backpressure.

---
 rtl/fibo_sequencer_if.sv | 33 +++
 rtl/fibo_sequencer.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/fibo_sequencer_if.sv
// Request, calculator and result-stream signals of the Fibonacci sequencer.
// master is the sequencer's view; slave is the surrounding logic's view.
interface fibo_sequencer_if;
  logic        start;
  logic [4:0]  first_n;
  logic [4:0]  last_n;
  logic        busy;
  logic        err;

  logic        fibo_begin;
  logic [4:0]  fibo_n;
  logic        fibo_done;
  logic [15:0] fibo_value;

  logic        out_valid;
  logic        out_ready;
  logic [4:0]  out_n;
  logic [15:0] out_value;
  logic        out_ovf;
  logic        out_last;

  modport master (
    input  start, first_n, last_n, fibo_done, fibo_value, out_ready,
    output busy, err, fibo_begin, fibo_n,
           out_valid, out_n, out_value, out_ovf, out_last
  );

  modport slave (
    output start, first_n, last_n, fibo_done, fibo_value, out_ready,
    input  busy, err, fibo_begin, fibo_n,
           out_valid, out_n, out_value, out_ovf, out_last
  );
endinterface

// File: rtl/fibo_sequencer.sv
// Walks first_n..last_n through the calculator, one request in flight; results land in a show-ahead FIFO.
// Result visible one cycle after done; a new request is withheld while the FIFO is full.
module fibo_sequencer #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned OVF_LIMIT  = 24
) (
  input  logic             clk,
  input  logic             reset_n,
  fibo_sequencer_if.master io
);

  localparam int unsigned AW      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [AW:0] DEPTH_C = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT
  } state_t;

  typedef struct packed {
    logic [4:0]  n;
    logic [15:0] value;
    logic        ovf;
    logic        last;
  } entry_t;

  state_t        r_state;
  logic [4:0]    r_cur_n;
  logic [4:0]    r_end_n;
  logic          r_busy;
  logic          r_err;
  logic          r_fibo_begin;

  entry_t        r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_cnt;

  logic          w_at_end;
  logic          w_push;
  logic          w_pop;
  logic          w_start_bad;
  logic          w_start_ok;
  logic          w_space_next;
  logic [AW:0]   w_cnt_next;
  entry_t        w_wr_entry;
  entry_t        w_head;

  always_comb begin
    w_at_end     = (r_cur_n == r_end_n);
    w_pop        = (r_cnt != '0) && io.out_ready;
    w_push       = (r_state == S_WAIT) && io.fibo_done && ((r_cnt != DEPTH_C) || w_pop);
    w_start_bad  = io.start && ((io.first_n == 5'd0) || (io.first_n > io.last_n));
    w_start_ok   = io.start && !w_start_bad;

    case ({w_push, w_pop})
      2'b10:   w_cnt_next = r_cnt + (AW + 1)'(1);
      2'b01:   w_cnt_next = r_cnt - (AW + 1)'(1);
      default: w_cnt_next = r_cnt;
    endcase
    // begin is registered, so the slot check is made against next cycle's occupancy
    w_space_next = (w_cnt_next < DEPTH_C);

    w_wr_entry = '{
      n:     r_cur_n,
      value: io.fibo_value,
      ovf:   (32'(r_cur_n) > OVF_LIMIT),
      last:  w_at_end
    };
    w_head = r_mem[r_rd_ptr];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= S_IDLE;
      r_cur_n      <= '0;
      r_end_n      <= '0;
      r_busy       <= 1'b0;
      r_err        <= 1'b0;
      r_fibo_begin <= 1'b0;
    end else begin
      r_err <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_fibo_begin <= 1'b0;
          if (w_start_ok) begin
            r_cur_n      <= io.first_n;
            r_end_n      <= io.last_n;
            r_busy       <= 1'b1;
            r_fibo_begin <= w_space_next;
            r_state      <= S_ISSUE;
          end else begin
            r_err <= w_start_bad;
          end
        end
        S_ISSUE: begin
          if (r_fibo_begin) begin
            r_fibo_begin <= 1'b0;
            r_state      <= S_WAIT;
          end else begin
            r_fibo_begin <= w_space_next;
          end
        end
        S_WAIT: begin
          // done is only trusted here; outside WAIT it may be left high by the previous run
          if (io.fibo_done) begin
            if (w_at_end) begin
              r_busy  <= 1'b0;
              r_state <= S_IDLE;
            end else begin
              r_cur_n      <= r_cur_n + 5'd1;
              r_fibo_begin <= w_space_next;
              r_state      <= S_ISSUE;
            end
          end
        end
        default: begin
          r_fibo_begin <= 1'b0;
          r_state      <= S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      r_cnt <= w_cnt_next;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= w_wr_entry;
    end
  end

  assign io.busy       = r_busy;
  assign io.err        = r_err;
  assign io.fibo_begin = r_fibo_begin;
  assign io.fibo_n     = r_cur_n;
  assign io.out_valid  = (r_cnt != '0);
  assign io.out_n      = w_head.n;
  assign io.out_value  = w_head.value;
  assign io.out_ovf    = w_head.ovf;
  assign io.out_last   = w_head.last;

endmodule
